// File: rtl/multi_mac_drv.sv
// multi_mac_drv: job initiator and result collector for the shift-add
// multiplier. A job of req_len operand pairs is accepted, each pair is issued
// to the multiplier one at a time, the partial products streaming back are
// summed into a signed accumulator, and the total is returned on a
// valid/ready response port together with a sticky overflow flag.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_vld/req_rdy/req_len  job request handshake and pair count
//   src_vld/src_rdy          operand pair handshake
//   src0_data/src1_data      signed operand A, unsigned operand B
//   multi_vld                one-cycle issue pulse to the multiplier
//   in0_data/in1_data        registered operands presented to the multiplier
//   multi_busy               multiplier busy
//   mul_out_vld/mul_out_data partial product stream from the multiplier
//   rsp_vld/rsp_rdy          result handshake
//   rsp_data/rsp_ovf         accumulated result and sticky overflow flag
module multi_mac_drv #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              src_vld,
  output logic              src_rdy,
  input  logic [7:0]        src0_data,
  input  logic [7:0]        src1_data,
  output logic              multi_vld,
  output logic [7:0]        in0_data,
  output logic [7:0]        in1_data,
  input  logic              multi_busy,
  input  logic              mul_out_vld,
  input  logic [15:0]       mul_out_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [ACC_W-1:0]  rsp_data,
  output logic              rsp_ovf
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_RSP
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] remaining;
  logic             ovf;
  logic [ACC_W-1:0] part_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             take_part;

  // Partial products are only meaningful while a pair is in flight; anything
  // arriving in other states (e.g. the tail of a job aborted by reset) is dropped.
  assign take_part = mul_out_vld && (state_q == ST_ISSUE || state_q == ST_WAIT);
  assign part_ext  = ACC_W'($signed(mul_out_data));
  assign sum       = acc + part_ext;
  // Signed overflow: both addends share a sign that the sum does not.
  assign add_ovf   = (acc[ACC_W-1] == part_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  assign rsp_data = acc;
  assign rsp_ovf  = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_rdy   = 1'b0;
    src_rdy   = 1'b0;
    multi_vld = 1'b0;
    rsp_vld   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_d = (req_len != '0) ? ST_FETCH : ST_RSP;
      end
      ST_FETCH: begin
        // Holding off while busy keeps at most one pair outstanding, so the
        // multiplier's input FIFO is never used.
        src_rdy = !multi_busy;
        if (src_vld && !multi_busy) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        multi_vld = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (!multi_busy) state_d = (remaining > LEN_W'(1)) ? ST_FETCH : ST_RSP;
      end
      ST_RSP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
      in0_data  <= '0;
      in1_data  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            remaining <= req_len;
            acc       <= '0;
            ovf       <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (src_vld && src_rdy) begin
            in0_data <= src0_data;
            in1_data <= src1_data;
          end
        end
        ST_WAIT: begin
          if (!multi_busy) remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
      // A partial arriving in the same cycle busy drops still belongs to this pair.
      if (take_part) begin
        acc <= sum;
        if (add_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_mac_drv.sv
// tb_multi_mac_drv: directed self-checking bench for multi_mac_drv. Two
// instances (ACC_W=24 and ACC_W=16) share one behavioural shift-add
// multiplier; sel16 picks which instance drives it.
module tb_multi_mac_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] req_len = '0;
  logic [7:0] src0 = '0, src1 = '0;
  logic       rsp_rdy = 1'b0;
  logic       sel16 = 1'b0;

  logic req_vld24 = 1'b0, src_vld24 = 1'b0;
  logic req_vld16 = 1'b0, src_vld16 = 1'b0;

  logic        req_rdy24, src_rdy24, mv24, rsp_vld24, ovf24;
  logic [7:0]  in0_24, in1_24;
  logic [23:0] rsp_data24;
  logic        req_rdy16, src_rdy16, mv16, rsp_vld16, ovf16;
  logic [7:0]  in0_16, in1_16;
  logic [15:0] rsp_data16;

  logic        multi_busy = 1'b0;
  logic        mul_out_vld = 1'b0;
  logic [15:0] mul_out_data = '0;

  int errors = 0;
  int checks = 0;
  int total_pulses = 0;
  int viol_cnt = 0;

  logic [7:0] pa [8];
  logic [7:0] pb [8];

  multi_mac_drv #(.ACC_W(24), .LEN_W(8)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld24), .req_rdy(req_rdy24), .req_len(req_len),
    .src_vld(src_vld24), .src_rdy(src_rdy24), .src0_data(src0), .src1_data(src1),
    .multi_vld(mv24), .in0_data(in0_24), .in1_data(in1_24), .multi_busy(multi_busy),
    .mul_out_vld(mul_out_vld), .mul_out_data(mul_out_data),
    .rsp_vld(rsp_vld24), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data24), .rsp_ovf(ovf24)
  );

  multi_mac_drv #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld16), .req_rdy(req_rdy16), .req_len(req_len),
    .src_vld(src_vld16), .src_rdy(src_rdy16), .src0_data(src0), .src1_data(src1),
    .multi_vld(mv16), .in0_data(in0_16), .in1_data(in1_16), .multi_busy(multi_busy),
    .mul_out_vld(mul_out_vld), .mul_out_data(mul_out_data),
    .rsp_vld(rsp_vld16), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data16), .rsp_ovf(ovf16)
  );

  logic       mv_sel, src_rdy_sel, rsp_vld_sel;
  logic [7:0] in0_sel, in1_sel;
  assign mv_sel      = sel16 ? mv16      : mv24;
  assign src_rdy_sel = sel16 ? src_rdy16 : src_rdy24;
  assign rsp_vld_sel = sel16 ? rsp_vld16 : rsp_vld24;
  assign in0_sel     = sel16 ? in0_16    : in0_24;
  assign in1_sel     = sel16 ? in1_16    : in1_24;

  // Behavioural multiplier: busy rises after an issue, then one partial
  // (signed A << k) per set bit of B, one per cycle; busy drops together with
  // the last partial, or one cycle after issue when B is zero.
  logic [15:0] parts [8];
  int pcnt = 0;
  int pidx = 0;
  always @(posedge clk) begin
    mul_out_vld <= 1'b0;
    if (!multi_busy) begin
      if (mv_sel) begin
        int n;
        logic [15:0] ext;
        n = 0;
        ext = {{8{in0_sel[7]}}, in0_sel};
        for (int k = 0; k < 8; k++) begin
          if (in1_sel[k]) begin
            parts[n] <= ext << k;
            n++;
          end
        end
        pcnt <= n;
        pidx <= 0;
        multi_busy <= 1'b1;
      end
    end else if (pidx < pcnt) begin
      mul_out_data <= parts[pidx];
      mul_out_vld  <= 1'b1;
      pidx         <= pidx + 1;
      if (pidx + 1 == pcnt) multi_busy <= 1'b0;
    end else begin
      multi_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mv_sel) total_pulses++;
    if (src_rdy_sel && multi_busy) viol_cnt++;
  end

  // Runs one job on the selected instance up to the point rsp_vld is seen.
  // rsp_wait is the number of extra cycles spent waiting for rsp_vld.
  task automatic do_job(input bit use16, input int len, output bit to, output int rsp_wait);
    int guard;
    to = 1'b0;
    sel16 = use16;
    @(negedge clk);
    req_len = 8'(len);
    if (use16) req_vld16 = 1'b1; else req_vld24 = 1'b1;
    @(negedge clk);
    req_vld16 = 1'b0;
    req_vld24 = 1'b0;
    for (int i = 0; i < len; i++) begin
      src0 = pa[i];
      src1 = pb[i];
      if (use16) src_vld16 = 1'b1; else src_vld24 = 1'b1;
      guard = 0;
      while (!src_rdy_sel && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) to = 1'b1;
      @(negedge clk);
      src_vld16 = 1'b0;
      src_vld24 = 1'b0;
    end
    guard = 0;
    while (!rsp_vld_sel && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) to = 1'b1;
    rsp_wait = guard;
  endtask

  task automatic release_rsp();
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_rdy24 !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_rdy: got %b expected 1", req_rdy24); end
    checks++; if (rsp_vld24 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_vld: got %b expected 0", rsp_vld24); end
    checks++; if (src_rdy24 !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_rdy: got %b expected 0", src_rdy24); end
    checks++; if (mv24 !== 1'b0) begin errors++; $display("[TB] FAIL reset_multi_vld: got %b expected 0", mv24); end
    checks++; if ({in0_24, in1_24} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_operands: got %h expected 0000", {in0_24, in1_24}); end
    checks++; if (rsp_data24 !== 24'h0 || ovf24 !== 1'b0) begin errors++; $display("[TB] FAIL reset_acc_ovf: got %h/%b expected 000000/0", rsp_data24, ovf24); end
    checks++; if (req_rdy16 !== 1'b1 || rsp_data16 !== 16'h0) begin errors++; $display("[TB] FAIL reset_dut16: got %b/%h expected 1/0000", req_rdy16, rsp_data16); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit to; int w; int p0;
    pa[0] = 8'hFD; pb[0] = 8'h05;
    p0 = total_pulses;
    do_job(1'b0, 1, to, w);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout: got %b expected 0", to); end
    checks++; if (rsp_data24 !== 24'hFFFFF1) begin errors++; $display("[TB] FAIL single_data: got %h expected fffff1", rsp_data24); end
    checks++; if (ovf24 !== 1'b0) begin errors++; $display("[TB] FAIL single_ovf: got %b expected 0", ovf24); end
    checks++; if (total_pulses - p0 !== 1) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected 1", total_pulses - p0); end
    release_rsp();
    checks++; if (rsp_vld24 !== 1'b0 || req_rdy24 !== 1'b1) begin errors++; $display("[TB] FAIL single_release: got %b/%b expected 0/1", rsp_vld24, req_rdy24); end
  endtask

  task automatic test_three_pairs();
    bit to; int w; int p0; int v0;
    pa[0] = 8'h02; pb[0] = 8'h03;
    pa[1] = 8'hFF; pb[1] = 8'h80;
    pa[2] = 8'h7F; pb[2] = 8'hFF;
    p0 = total_pulses;
    v0 = viol_cnt;
    do_job(1'b0, 3, to, w);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL three_timeout: got %b expected 0", to); end
    checks++; if (rsp_data24 !== 24'd32263) begin errors++; $display("[TB] FAIL three_data: got %0d expected 32263", rsp_data24); end
    checks++; if (ovf24 !== 1'b0) begin errors++; $display("[TB] FAIL three_ovf: got %b expected 0", ovf24); end
    checks++; if (total_pulses - p0 !== 3) begin errors++; $display("[TB] FAIL three_pulses: got %0d expected 3", total_pulses - p0); end
    checks++; if (viol_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL three_src_rdy_busy: got %0d expected 0", viol_cnt - v0); end
    release_rsp();
  endtask

  task automatic test_zero_len();
    bit to; int w; int p0;
    p0 = total_pulses;
    do_job(1'b0, 0, to, w);
    checks++; if (w !== 0 || rsp_vld24 !== 1'b1) begin errors++; $display("[TB] FAIL zero_len_latency: got wait=%0d vld=%b expected 0/1", w, rsp_vld24); end
    checks++; if (rsp_data24 !== 24'h0) begin errors++; $display("[TB] FAIL zero_len_data: got %h expected 000000", rsp_data24); end
    checks++; if (total_pulses - p0 !== 0) begin errors++; $display("[TB] FAIL zero_len_pulses: got %0d expected 0", total_pulses - p0); end
    release_rsp();
  endtask

  task automatic test_zero_operand();
    bit to; int w; int p0;
    pa[0] = 8'h05; pb[0] = 8'h07;
    pa[1] = 8'h09; pb[1] = 8'h00;
    p0 = total_pulses;
    do_job(1'b0, 2, to, w);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL zero_op_timeout: got %b expected 0", to); end
    checks++; if (rsp_data24 !== 24'd35) begin errors++; $display("[TB] FAIL zero_op_data: got %0d expected 35", rsp_data24); end
    checks++; if (total_pulses - p0 !== 2) begin errors++; $display("[TB] FAIL zero_op_pulses: got %0d expected 2", total_pulses - p0); end
    release_rsp();
  endtask

  task automatic test_overflow_hold();
    bit to; int w;
    pa[0] = 8'h7F; pb[0] = 8'hFF;
    pa[1] = 8'h7F; pb[1] = 8'hFF;
    do_job(1'b1, 2, to, w);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL ovf_timeout: got %b expected 0", to); end
    checks++; if (rsp_data16 !== 16'hFD02) begin errors++; $display("[TB] FAIL ovf_data: got %h expected fd02", rsp_data16); end
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", ovf16); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_vld16 !== 1'b1 || rsp_data16 !== 16'hFD02 || ovf16 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ovf_hold_%0d: got %b/%h/%b expected 1/fd02/1", c, rsp_vld16, rsp_data16, ovf16);
      end
    end
    release_rsp();
    checks++; if (rsp_vld16 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_release: got %b expected 0", rsp_vld16); end
    sel16 = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    bit to; int w; int guard;
    sel16 = 1'b0;
    @(negedge clk);
    req_len = 8'd3;
    req_vld24 = 1'b1;
    @(negedge clk);
    req_vld24 = 1'b0;
    src0 = 8'd100; src1 = 8'hFF; src_vld24 = 1'b1;
    guard = 0;
    while (!src_rdy24 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    src_vld24 = 1'b0;
    guard = 0;
    while (!multi_busy && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (multi_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_reach_wait: got busy=%b expected 1", multi_busy); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req_rdy24 !== 1'b1 || rsp_vld24 !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got %b/%b expected 1/0", req_rdy24, rsp_vld24); end
    checks++; if (rsp_data24 !== 24'h0) begin errors++; $display("[TB] FAIL mid_reset_acc: got %h expected 000000", rsp_data24); end
    rst_n = 1'b1;
    pa[0] = 8'h04; pb[0] = 8'h04;
    do_job(1'b0, 1, to, w);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_timeout: got %b expected 0", to); end
    checks++; if (rsp_data24 !== 24'd16 || ovf24 !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_data: got %0d/%b expected 16/0", rsp_data24, ovf24); end
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_pairs();
    test_zero_len();
    test_zero_operand();
    test_overflow_hold();
    test_reset_mid_job();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
